// File: rtl/i_vector_sram_writer.sv
// Packs a stream of 16-bit I values four-per-word and writes them into the I SRAM,
// storing value index k at word k[9:2], lane k[1:0] to match the I-value read path.
module i_vector_sram_writer #(
  parameter int DATA_WIDTH  = 16,
  parameter int LANES       = 4,
  parameter int INDEX_WIDTH = 10,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [DATA_WIDTH-1:0]       I_value_in,
  input  logic                        I_valid,
  input  logic                        I_last,
  output logic                        I_ready,
  output logic                        I_sram_write_en,
  output logic [ADDR_WIDTH-1:0]       I_sram_write_addr,
  output logic [DATA_WIDTH*LANES-1:0] I_sram_write_data,
  output logic [LANES-1:0]            I_sram_lane_mask,
  output logic                        busy,
  output logic                        done
);

  localparam int LANE_BITS  = INDEX_WIDTH - ADDR_WIDTH;
  localparam int WORD_WIDTH = DATA_WIDTH * LANES;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] index;
  logic [WORD_WIDTH-1:0]  pack;
  logic [LANES-1:0]       mask;
  logic                   last_seen;

  logic [LANE_BITS-1:0]   lane;
  logic [WORD_WIDTH-1:0]  pack_next;
  logic [LANES-1:0]       mask_next;
  logic                   accept;
  logic                   vector_end;
  logic                   word_done;

  assign lane       = index[LANE_BITS-1:0];
  assign accept     = (state == FILL) && I_valid && I_ready;
  // The top index is an implicit last: the counter must never wrap onto word 0.
  assign vector_end = I_last || (&index);
  assign word_done  = (&lane) || vector_end;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pack_next = pack;
    mask_next = mask;
    for (int n = 0; n < LANES; n++) begin
      if (lane == LANE_BITS'(n)) begin
        pack_next[n*DATA_WIDTH +: DATA_WIDTH] = I_value_in;
        mask_next[n]                          = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      index             <= '0;
      pack              <= '0;
      mask              <= '0;
      last_seen         <= 1'b0;
      I_ready           <= 1'b0;
      I_sram_write_en   <= 1'b0;
      I_sram_write_addr <= '0;
      I_sram_write_data <= '0;
      I_sram_lane_mask  <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            index     <= '0;
            pack      <= '0;
            mask      <= '0;
            last_seen <= 1'b0;
            I_ready   <= 1'b1;
            busy      <= 1'b1;
            state     <= FILL;
          end
        end

        FILL: begin
          if (accept) begin
            pack <= pack_next;
            mask <= mask_next;
            if (!(&index)) index <= index + INDEX_WIDTH'(1);
            if (word_done) begin
              // The completed word goes straight to the write port registers.
              I_ready           <= 1'b0;
              I_sram_write_en   <= 1'b1;
              I_sram_write_addr <= index[INDEX_WIDTH-1:LANE_BITS];
              I_sram_write_data <= pack_next;
              I_sram_lane_mask  <= mask_next;
              last_seen         <= vector_end;
              state             <= WRITE;
            end
          end
        end

        WRITE: begin
          I_sram_write_en <= 1'b0;
          pack            <= '0;
          mask            <= '0;
          if (last_seen) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            I_ready <= 1'b1;
            state   <= FILL;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
